data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Behavioural-synthesizable data-memory slave: the responder end of the core's data memory interface (req/gnt/rvalid handshake, addr, we, be, wdata, rdata).
- Sits in the testbench top between the core's data port and the GUVM environment.
- Provides word-organised storage, a programmable grant stall, fixed-latency in-order responses and access counters for scoreboarding.

Parameters:
- MEM_WORDS, 1024, storage depth in 32-bit words (power of two).
- BASE_ADDR, 32'h0010_0000, byte address of word 0; must be aligned to MEM_WORDS*4.
- RESP_LAT, 1, cycles from grant to rvalid (1..4).
- OOR_DATA, 32'hDEAD_BEEF, rdata returned for out-of-range reads.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- data_req_i  input  1  request from core.
- data_we_i  input  1  1 = write, 0 = read.
- data_be_i  input  4  byte enables, bit n gates byte lane n.
- data_addr_i  input  32  byte address; bits [1:0] ignored.
- data_wdata_i  input  32  write data.
- data_gnt_o  output  1  grant, combinational.
- data_rvalid_o  output  1  response valid.
- data_rdata_o  output  32  read data, qualified by rvalid.
- gnt_stall_i  input  4  wait cycles inserted before each grant (0 = same-cycle grant).
- rd_count_o  output  32  granted reads.
- wr_count_o  output  32  granted writes.
- oor_count_o  output  16  granted out-of-range accesses.

Behaviour:
- Reset, asynchronous: data_rvalid_o=0, data_rdata_o=0, all counters 0, FSM=IDLE, response pipeline cleared. Memory contents are not reset.
- In range means (addr - BASE_ADDR) < MEM_WORDS*4. Word index = (addr - BASE_ADDR)[log2(MEM_WORDS)+1:2].
- Grant FSM, states IDLE and WAIT:
  - IDLE, req=1, gnt_stall_i=0: data_gnt_o=1 in the same cycle.
  - IDLE, req=1, gnt_stall_i=N>0: load counter with N, go to WAIT; gnt=0.
  - WAIT: decrement the counter each cycle. When the counter is 1, assert gnt combinationally with req and return to IDLE.
  - Stall value is sampled only on the IDLE->WAIT transition.
- Core rule: addr/we/be/wdata are stable while req is held ungranted. The block does not re-check this.
- If req drops while in WAIT (protocol violation), return to IDLE with no grant and no response.
- gnt is never asserted without req.
- Accepted transaction = req & gnt in a cycle.
- Write, in range: on the accept edge, each byte lane with be[n]=1 is written; lanes with be[n]=0 are unchanged. be=0 is legal (no change, still counted).
- Read, in range: the full 32-bit word is captured at accept (byte lanes not masked). A write and a read to the same word cannot be accepted in one cycle.
- Out of range: write dropped; read returns OOR_DATA; oor_count_o increments. rd/wr counts still increment.
- Response pipeline: RESP_LAT-stage shift register of {valid, rdata}, advancing every cycle.
  - data_rvalid_o=1 exactly RESP_LAT cycles after each accept, for one cycle per transaction, in order.
  - Back-to-back accepts give back-to-back rvalids.
  - Writes also produce rvalid, with data_rdata_o=0.
  - The pipeline cannot be stalled; the core always accepts rvalid.
- Counters increment on accept and wrap at full width with no saturation.
- Read of a word in the cycle after a write to it returns the new data.
- Reset asserted mid-operation: in-flight responses are discarded and no rvalid is emitted after reset release. Memory keeps its contents.

Test Plan:
- Reset, then write addr 0x0010_0010, be=4'hF, wdata=0x1234_5678; read the same address with stall=0 → gnt in the same cycle as req, rvalid 1 cycle after grant, rdata=0x1234_5678. Expected wr_count=1, rd_count=1.
- Partial write: be=4'b0101, wdata=0xAABB_CCDD over 0x1234_5678, then read → rdata=0x12BB_56DD.
- gnt_stall_i=3, read held → gnt asserted on the 4th req cycle. Change stall to 0 mid-WAIT → still 3 waits.
- Read 0x0000_0004 (below BASE) and 0x0010_1000 (MEM_WORDS=1024, one past end) → rdata=0xDEAD_BEEF both times, oor_count=2. Write there and re-read in-range word 0 → unchanged.
- Back-to-back reads of 4 words with RESP_LAT=3, stall 0 → 4 consecutive rvalids starting 3 cycles after the first grant, in request order.
- Assert rst_ni low for 1 cycle between accept and rvalid → no rvalid appears; counters read 0 after release; earlier written data still reads back.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory slave for the core's req/gnt/rvalid port: word storage, programmable
// grant stall, fixed-latency in-order responses and access counters.
module data_mem_responder #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
    parameter int          RESP_LAT  = 1,
    parameter logic [31:0] OOR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    input  logic [3:0]  gnt_stall_i,
    output logic [31:0] rd_count_o,
    output logic [31:0] wr_count_o,
    output logic [15:0] oor_count_o
);

    localparam int          AW   = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN = 32'(MEM_WORDS * 4);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        gnt;
    logic        accept;
    logic [31:0] offset;
    logic        in_range;
    logic [AW-1:0] word_idx;
    logic [31:0] resp_data;

    logic [31:0] mem [MEM_WORDS];

    logic [RESP_LAT-1:0]       valid_sr_reg;
    logic [RESP_LAT-1:0][31:0] data_sr_reg;

    logic [31:0] rd_count_reg, wr_count_reg;
    logic [15:0] oor_count_reg;

    // Unsigned subtraction makes addresses below the base wrap high, so one compare covers both ends.
    assign offset   = data_addr_i - BASE_ADDR;
    assign in_range = (offset < SPAN);
    assign word_idx = offset[AW+1:2];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gnt        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (data_req_i) begin
                    if (gnt_stall_i == 4'd0) begin
                        gnt = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = gnt_stall_i;
                    end
                end
            end
            WAIT: begin
                if (!data_req_i) begin
                    state_next = IDLE;
                end else if (cnt_reg == 4'd1) begin
                    gnt        = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign data_gnt_o = gnt;
    assign accept     = data_req_i & gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (accept && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        resp_data = 32'd0;
        if (!data_we_i) begin
            resp_data = in_range ? mem[word_idx] : OOR_DATA;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_sr_reg <= '0;
            data_sr_reg  <= '0;
        end else begin
            valid_sr_reg[0] <= accept;
            data_sr_reg[0]  <= accept ? resp_data : 32'd0;
            for (int i = 1; i < RESP_LAT; i++) begin
                valid_sr_reg[i] <= valid_sr_reg[i-1];
                data_sr_reg[i]  <= data_sr_reg[i-1];
            end
        end
    end

    assign data_rvalid_o = valid_sr_reg[RESP_LAT-1];
    assign data_rdata_o  = data_sr_reg[RESP_LAT-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_count_reg  <= 32'd0;
            wr_count_reg  <= 32'd0;
            oor_count_reg <= 16'd0;
        end else if (accept) begin
            if (data_we_i) begin
                wr_count_reg <= wr_count_reg + 32'd1;
            end else begin
                rd_count_reg <= rd_count_reg + 32'd1;
            end
            if (!in_range) begin
                oor_count_reg <= oor_count_reg + 16'd1;
            end
        end
    end

    assign rd_count_o  = rd_count_reg;
    assign wr_count_o  = wr_count_reg;
    assign oor_count_o = oor_count_reg;

endmodule
